// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse_capture block: register map, CTRL and
// STATUS bit positions, FSM state encoding.
package pulse_capture_pkg;

   // register addresses
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_RESULT = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_LIMIT  = 2'd3;

   // CTRL bit positions
   localparam int CTRL_START = 0;
   localparam int CTRL_MODE  = 1;
   localparam int CTRL_IRQEN = 2;

   // STATUS bit positions
   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_MODE      = 3;
   localparam int STAT_STATE_LSB = 4;

   // measurement FSM encoding (visible in STATUS[5:4])
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2,
      ST_DONE = 2'd3
   } cap_state_t;

endpackage

// File: rtl/pulse_capture_sync_edge.sv
// Input synchronizer followed by an edge detector. The asynchronous input
// passes SYNC_STAGES flops, then one more flop holds the previous value so
// rise/fall are single-cycle pulses derived purely from registered signals.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   // synchronizer chain plus previous-value flop, all cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~prev;
   assign fall = ~sync[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/pulse_capture.sv
// Pulse width / period capture unit with a small CPU register interface.
// Optional interrupt output enabled by defining PULSE_CAPTURE_IRQ_EN.
module pulse_capture
   import pulse_capture_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cap_in,
   input  logic        tick,
   input  logic        cap_we,
   input  logic        cap_re,
   input  logic [1:0]  cap_addr,
   input  logic [31:0] cap_wdata,
   output logic [31:0] cap_rdata,
   output logic        cap_busy,
   output logic        cap_done
`ifdef PULSE_CAPTURE_IRQ_EN
   ,
   output logic        cap_irq
`endif
);

   cap_state_t       state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] result;
   logic [CNT_W-1:0] limit;
   logic             mode;
   logic             ovf;
   logic             rise;
   logic             fall;
   logic             ctrl_wr;
   logic             start;
   logic             rd_result;
   logic             term_edge;
   logic             hit_limit;
`ifdef PULSE_CAPTURE_IRQ_EN
   logic             irqen;
   logic             irqen_nxt;
`endif

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (cap_in),
      .rise (rise),
      .fall (fall)
   );

   assign ctrl_wr   = cap_we && (cap_addr == ADDR_CTRL);
   assign start     = ctrl_wr && cap_wdata[CTRL_START];
   assign rd_result = cap_re && (cap_addr == ADDR_RESULT);

   // mode 0 ends on the falling edge, mode 1 on the next rising edge
   assign term_edge = mode ? rise : fall;

   // saturating increment; a tick at all-ones leaves the counter unchanged
   assign count_nxt = (tick && (count != '1)) ? count + CNT_W'(1) : count;

   // overflow when the counter just stepped onto LIMIT (nonzero) or all-ones
   assign hit_limit = tick && (((limit != '0) && (count_nxt == limit)) ||
                               (count_nxt == '1));

`ifdef PULSE_CAPTURE_IRQ_EN
   assign irqen_nxt = ctrl_wr ? cap_wdata[CTRL_IRQEN] : irqen;
`endif

   // software-written configuration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode  <= 1'b0;
         limit <= '0;
`ifdef PULSE_CAPTURE_IRQ_EN
         irqen <= 1'b0;
`endif
      end else if (cap_we) begin
         case (cap_addr)
            ADDR_CTRL: begin
               mode  <= cap_wdata[CTRL_MODE];
`ifdef PULSE_CAPTURE_IRQ_EN
               irqen <= cap_wdata[CTRL_IRQEN];
`endif
            end
            ADDR_LIMIT: limit <= cap_wdata[CNT_W-1:0];
            default: ;
         endcase
      end
   end

   // measurement FSM with registered busy/done/ovf/irq outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         result   <= '0;
         ovf      <= 1'b0;
         cap_busy <= 1'b0;
         cap_done <= 1'b0;
`ifdef PULSE_CAPTURE_IRQ_EN
         cap_irq  <= 1'b0;
`endif
      end else if (start) begin
         // start from any state (re)arms; it also wins over a terminating edge
         state    <= ST_ARM;
         count    <= '0;
         ovf      <= 1'b0;
         cap_busy <= 1'b1;
         cap_done <= 1'b0;
`ifdef PULSE_CAPTURE_IRQ_EN
         cap_irq  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: ;
            ST_ARM: begin
               if (rise) begin
                  state <= ST_MEAS;
                  count <= '0;
               end
            end
            ST_MEAS: begin
               count <= count_nxt;
               if (term_edge || hit_limit) begin
                  state    <= ST_DONE;
                  result   <= count_nxt;
                  ovf      <= hit_limit;
                  cap_busy <= 1'b0;
                  cap_done <= 1'b1;
`ifdef PULSE_CAPTURE_IRQ_EN
                  cap_irq  <= irqen_nxt;
`endif
               end
            end
            ST_DONE: begin
               if (rd_result && cap_done) begin
                  cap_done <= 1'b0;
`ifdef PULSE_CAPTURE_IRQ_EN
                  cap_irq  <= 1'b0;
`endif
               end
`ifdef PULSE_CAPTURE_IRQ_EN
               else begin
                  cap_irq <= cap_done & irqen_nxt;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // combinational read mux; registers zero-extended to 32 bits
   always_comb begin
      cap_rdata = '0;
      case (cap_addr)
         ADDR_CTRL: begin
            cap_rdata[CTRL_MODE] = mode;
`ifdef PULSE_CAPTURE_IRQ_EN
            cap_rdata[CTRL_IRQEN] = irqen;
`endif
         end
         ADDR_RESULT: cap_rdata = 32'(result);
         ADDR_STATUS: begin
            cap_rdata[STAT_BUSY]               = cap_busy;
            cap_rdata[STAT_DONE]               = cap_done;
            cap_rdata[STAT_OVF]                = ovf;
            cap_rdata[STAT_MODE]               = mode;
            cap_rdata[STAT_STATE_LSB +: 2]     = state;
         end
         ADDR_LIMIT: cap_rdata = 32'(limit);
         default: cap_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_pulse_capture.sv
// Self-checking bench for pulse_capture. Expected RESULT values are pushed
// on a scoreboard queue when a pulse is driven and popped when read back.
module tb_pulse_capture;
   import pulse_capture_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cap_in = 1'b0;
   logic        tick = 1'b0;
   logic        cap_we = 1'b0;
   logic        cap_re = 1'b0;
   logic [1:0]  cap_addr = 2'd0;
   logic [31:0] cap_wdata = '0;
   logic [31:0] cap_rdata;
   logic        cap_busy;
   logic        cap_done;
`ifdef PULSE_CAPTURE_IRQ_EN
   logic        cap_irq;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   int          tick_div = 1;
   int          tick_cnt = 0;
   logic [31:0] exp_q[$];

   pulse_capture #(.SYNC_STAGES(2), .CNT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .cap_in    (cap_in),
      .tick      (tick),
      .cap_we    (cap_we),
      .cap_re    (cap_re),
      .cap_addr  (cap_addr),
      .cap_wdata (cap_wdata),
      .cap_rdata (cap_rdata),
      .cap_busy  (cap_busy),
      .cap_done  (cap_done)
`ifdef PULSE_CAPTURE_IRQ_EN
      ,
      .cap_irq   (cap_irq)
`endif
   );

   always #5 clk = ~clk;

   // tick generator: one pulse every tick_div clocks
   always begin
      @(posedge clk);
      #1;
      tick_cnt++;
      tick = ((tick_cnt % tick_div) == 0);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
      cap_we = 1'b1; cap_addr = a; cap_wdata = d;
      @(posedge clk); #1;
      cap_we = 1'b0; cap_wdata = '0;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
      cap_re = 1'b1; cap_addr = a;
      #1;
      d = cap_rdata;
      @(posedge clk); #1;
      cap_re = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int i;
      i = 0;
      while (cap_done !== 1'b1 && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      n_tests++;
      if (cap_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: cap_done=%b required 1 within %0d cycles", name, cap_done, budget);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      n_tests++;
      if (cap_busy !== 1'b0 || cap_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b required 0 0", cap_busy, cap_done);
      end
      step(2);
      rst = 1'b0;
      step(2);
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
      exp_q.push_back(32'h0);
      cpu_read(ADDR_RESULT, d);
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL reset_result: got %h want 0", d); end
      cpu_read(ADDR_LIMIT, d);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_limit: got %h want 0", d); end
   endtask

   task automatic test_ctrl();
      logic [31:0] d;
      logic [31:0] e;
      cpu_write(ADDR_CTRL, 32'h6);
      cpu_read(ADDR_CTRL, d);
`ifdef PULSE_CAPTURE_IRQ_EN
      e = 32'h6;
`else
      e = 32'h2;
`endif
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL ctrl_readback: got %h want %h", d, e); end
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h8) begin n_fail++; $display("FAIL ctrl_no_start: status got %h want 8", d); end
      cpu_write(ADDR_CTRL, 32'h0);
   endtask

   task automatic test_rw_same();
      logic [31:0] d;
      cpu_write(ADDR_LIMIT, 32'd7);
      exp_q.push_back(32'd7);
      cap_we = 1'b1; cap_re = 1'b1; cap_addr = ADDR_LIMIT; cap_wdata = 32'd9;
      #1;
      d = cap_rdata;
      @(posedge clk); #1;
      cap_we = 1'b0; cap_re = 1'b0;
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL rw_same_old: got %h want 7", d); end
      cpu_read(ADDR_LIMIT, d);
      n_tests++;
      if (d !== 32'd9) begin n_fail++; $display("FAIL rw_same_new: got %h want 9", d); end
      cpu_write(ADDR_LIMIT, 32'd0);
   endtask

   task automatic test_width();
      logic [31:0] d;
      tick_div = 1;
      cpu_write(ADDR_CTRL, 32'h1);
      cap_in = 1'b1;
      exp_q.push_back(32'd100);
      step(100);
      cap_in = 1'b0;
      wait_done(20, "width");
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h32) begin n_fail++; $display("FAIL width_status: got %h want 32", d); end
      cpu_read(ADDR_RESULT, d);
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL width_result: got %0d want 100", d); end
   endtask

   task automatic test_period();
      logic [31:0] d;
      tick_div = 4;
      cpu_write(ADDR_CTRL, 32'h3);
      exp_q.push_back(32'd100);
      for (int p = 0; p < 2; p++) begin
         cap_in = 1'b1;
         step(200);
         cap_in = 1'b0;
         step(200);
      end
      wait_done(20, "period");
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h3A) begin n_fail++; $display("FAIL period_status: got %h want 3a", d); end
      cpu_read(ADDR_RESULT, d);
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL period_result: got %0d want 100", d); end
      n_tests++;
      if (cap_done !== 1'b0) begin n_fail++; $display("FAIL period_done_clear: cap_done=%b want 0", cap_done); end
      exp_q.push_back(32'd100);
      cpu_read(ADDR_RESULT, d);
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL period_reread: got %0d want 100", d); end
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h38) begin n_fail++; $display("FAIL period_status_after: got %h want 38", d); end
      tick_div = 1;
   endtask

   task automatic test_limit();
      logic [31:0] d;
      tick_div = 1;
      cpu_write(ADDR_LIMIT, 32'd50);
      cpu_write(ADDR_CTRL, 32'h1);
      cap_in = 1'b1;
      exp_q.push_back(32'd50);
      step(70);
      n_tests++;
      if (cap_done !== 1'b1) begin n_fail++; $display("FAIL limit_early_done: cap_done=%b want 1", cap_done); end
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h36) begin n_fail++; $display("FAIL limit_status: got %h want 36", d); end
      step(129);
      cap_in = 1'b0;
      step(10);
      cpu_read(ADDR_RESULT, d);
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL limit_result: got %0d want 50", d); end
      cpu_write(ADDR_LIMIT, 32'd0);
   endtask

   task automatic test_abort();
      logic [31:0] d;
      tick_div = 1;
      cpu_write(ADDR_CTRL, 32'h1);
      cap_in = 1'b1;
      step(35);
      cpu_write(ADDR_CTRL, 32'h1);
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h11) begin n_fail++; $display("FAIL abort_rearm: status got %h want 11", d); end
      cap_in = 1'b0;
      step(10);
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h11) begin n_fail++; $display("FAIL abort_fall_ignored: status got %h want 11", d); end
      cap_in = 1'b1;
      exp_q.push_back(32'd20);
      step(20);
      cap_in = 1'b0;
      wait_done(20, "abort");
      cpu_read(ADDR_RESULT, d);
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL abort_result: got %0d want 20", d); end
   endtask

`ifdef PULSE_CAPTURE_IRQ_EN
   task automatic test_irq();
      logic [31:0] d;
      tick_div = 1;
      cpu_write(ADDR_CTRL, 32'h5);
      cap_in = 1'b1;
      exp_q.push_back(32'd10);
      step(10);
      cap_in = 1'b0;
      wait_done(20, "irq");
      n_tests++;
      if (cap_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: cap_irq=%b want 1", cap_irq); end
      cpu_read(ADDR_RESULT, d);
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL irq_result: got %0d want 10", d); end
      n_tests++;
      if (cap_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: cap_irq=%b want 0", cap_irq); end
      cpu_write(ADDR_CTRL, 32'h0);
   endtask
`endif

   task automatic test_rst_mid();
      logic [31:0] d;
      tick_div = 1;
      cpu_write(ADDR_CTRL, 32'h1);
      cap_in = 1'b1;
      step(20);
      rst = 1'b1;
      #1;
      n_tests++;
      if (cap_busy !== 1'b0 || cap_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: busy=%b done=%b want 0 0", cap_busy, cap_done);
      end
      step(2);
      rst = 1'b0;
      step(1);
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status: got %h want 0", d); end
      cap_in = 1'b0;
      step(10);
      cpu_read(ADDR_STATUS, d);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status_after_fall: got %h want 0", d); end
      exp_q.push_back(32'h0);
      cpu_read(ADDR_RESULT, d);
      n_tests++;
      if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL rst_mid_result: got %0d want 0", d); end
   endtask

   initial begin
      #1;
      test_reset();
      test_ctrl();
      test_rw_same();
      test_width();
      test_period();
      test_limit();
      test_abort();
`ifdef PULSE_CAPTURE_IRQ_EN
      test_irq();
`endif
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_capture.md
PULSE_CAPTURE -- requirements
Module: pulse_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (legal 2..4).
REQ-002 SHALL have parameter CNT_W, default 32, width of measurement counter and result.
REQ-003 clk  input  1  system clock; reset rst, asynchronous, active-high; clock clk.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 cap_in  input  1  external pulse input, asynchronous to clk.
REQ-006 tick  input  1  count enable, one clk wide per prescaled period (e.g. divided clock edge).
REQ-007 cap_we  input  1  CPU write strobe.
REQ-008 cap_re  input  1  CPU read strobe.
REQ-009 cap_addr  input  2  register select: 0 CTRL, 1 RESULT, 2 STATUS, 3 LIMIT.
REQ-010 cap_wdata  input  32  CPU write data.
REQ-011 cap_rdata  output  32  CPU read data, combinational on cap_addr.
REQ-012 cap_busy  output  1  measurement in progress (ARM or MEAS).
REQ-013 cap_done  output  1  result valid, not yet read.

Function
REQ-014 cap_in SHALL pass SYNC_STAGES flops then one edge-detect flop; an edge SHALL be acted on SYNC_STAGES+1 clk after it is sampled.
REQ-015 CTRL write: bit0 start, bit1 mode (0 high-pulse width, 1 period rising-to-rising); bit1 stored, bit0 self-clearing.
REQ-016 FSM states IDLE, ARM, MEAS, DONE; reset state IDLE.
REQ-017 IDLE/DONE --start--> ARM; counter cleared, done and ovf cleared.
REQ-018 ARM --synchronized rising edge--> MEAS; counter cleared to 0 on that cycle.
REQ-019 MEAS: counter +1 on each clk with tick=1; no change without tick.
REQ-020 MEAS --falling edge (mode 0) or next rising edge (mode 1)--> DONE; RESULT latches counter value including any tick in the same cycle.
REQ-021 MEAS: counter SHALL saturate at all-ones; on reaching LIMIT (if LIMIT nonzero) or saturation, RESULT latches counter, STATUS.ovf set, go DONE.
REQ-022 Start written while in ARM or MEAS SHALL abort and re-enter ARM with counter cleared; start wins over a simultaneous terminating edge.
REQ-023 cap_done =1 in DONE until cap_re with cap_addr=1; that read returns RESULT and clears done next cycle; FSM stays DONE until start.
REQ-024 Read of RESULT while not done SHALL return last latched value and have no side effect.
REQ-025 STATUS read: bit0 busy, bit1 done, bit2 ovf, bit3 mode, bits[5:4] FSM state; other bits 0.
REQ-026 CNT_W<32: RESULT/LIMIT zero-extended on read, upper wdata bits ignored.
REQ-027 cap_we with cap_re same cycle: write takes effect, read returns pre-write value.

Reset
REQ-028 rst SHALL force IDLE, counter/RESULT/LIMIT/mode/ovf/done = 0, synchronizer flops = 0, cap_busy=0, cap_done=0, cap_irq=0.
REQ-029 rst mid-measurement SHALL abort with no RESULT update; no edge is detected on the first cycle after rst deasserts.

Configuration
REQ-030 Macro PULSE_CAPTURE_IRQ_EN defined: output cap_irq (1 bit) and CTRL bit2 irqen exist; cap_irq = done & irqen, registered, clears with done.
REQ-031 Macro undefined: no cap_irq port, CTRL bit2 reads 0, write ignored.

Structure
REQ-032 Shared package SHALL hold register address constants, CTRL/STATUS bit positions, FSM state encoding.
REQ-033 Synchronizer plus edge detector SHALL be one sub-module, sync_edge, outputting rise and fall pulses.

Verification
REQ-034 mode 0, tick every clk, cap_in high 100 clk -> RESULT=100 (±0), done=1, ovf=0.
REQ-035 mode 1, tick every 4th clk, cap_in period 400 clk -> RESULT=100; RESULT read clears done next cycle.
REQ-036 LIMIT=50, mode 0, pulse 200 ticks -> RESULT=50, ovf=1, DONE before falling edge.
REQ-037 start rewritten 30 ticks into MEAS -> FSM ARM, counter 0; next 20-tick pulse -> RESULT=20.
REQ-038 rst asserted in MEAS -> all outputs 0, STATUS=0 next read; falling edge afterward causes no update.
REQ-039 PULSE_CAPTURE_IRQ_EN with irqen=1 -> cap_irq rises with done, falls the cycle after RESULT read.
